// File: rtl/axi_pkg.sv
// Shared encodings for the AXI slave bridge: response codes, burst types,
// bridge state encoding and the response-merge helper.
package axi_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'd0,
        RESP_EXOKAY = 2'd1,
        RESP_SLVERR = 2'd2,
        RESP_DECERR = 2'd3
    } resp_e;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'd0,
        BURST_INCR  = 2'd1,
        BURST_WRAP  = 2'd2,
        BURST_RSVD  = 2'd3
    } burst_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RDREQ  = 3'd1,
        ST_RDRESP = 3'd2,
        ST_WRDATA = 3'd3,
        ST_WRREQ  = 3'd4,
        ST_WRRESP = 3'd5
    } state_e;

    // Severity ordering DECERR > SLVERR > OKAY matches the numeric encoding.
    function automatic resp_e resp_worst(input resp_e a, input resp_e b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/axi_addr_gen.sv
// Combinational next-beat address for FIXED, INCR and WRAP bursts.
module axi_addr_gen
    import axi_pkg::*;
#(
    parameter int unsigned ADDR    = 32,
    parameter int unsigned LENBITS = 4
) (
    input  logic [ADDR-1:0]    addr,
    input  logic [2:0]         size,
    input  logic [LENBITS-1:0] len,
    input  logic [1:0]         burst,
    output logic [ADDR-1:0]    next_addr_c
);

    logic [ADDR-1:0] size_bytes;
    logic [ADDR-1:0] incr_addr;
    logic [ADDR-1:0] container;
    logic [ADDR-1:0] wrap_mask;
    logic            wrap_ok;

    always_comb begin
        size_bytes  = ADDR'(1) << size;
        incr_addr   = addr + size_bytes;
        container   = (ADDR'(len) + ADDR'(1)) << size;
        wrap_mask   = container - ADDR'(1);
        // Only power-of-two burst lengths 2..16 wrap; anything else behaves as INCR.
        wrap_ok     = (len == LENBITS'(1)) || (len == LENBITS'(3)) ||
                      (len == LENBITS'(7)) || (len == LENBITS'(15));
        next_addr_c = incr_addr;
        case (burst_e'(burst))
            BURST_FIXED: next_addr_c = addr;
            BURST_WRAP: begin
                if (wrap_ok) begin
                    next_addr_c = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
                end
            end
            default: next_addr_c = incr_addr;
        endcase
    end

endmodule

// File: rtl/axi_slave_bridge.sv
// AXI3/AXI4 slave that serialises bursts into single-beat outreq/outack
// register-bus accesses with round-robin read/write arbitration and timeout.
module axi_slave_bridge
    import axi_pkg::*;
#(
    parameter int unsigned ADDR     = 32,
    parameter int unsigned DATA     = 32,
    parameter int unsigned ID       = 12,
    parameter int unsigned LENBITS  = 4,
    parameter int unsigned TIMEBITS = 20,
    parameter int unsigned TIMEOUT  = 2**TIMEBITS - 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    // write address
    input  logic                 awvalid,
    output logic                 awready,
    input  logic [ADDR-1:0]      awaddr,
    input  logic [LENBITS-1:0]   awlen,
    input  logic [2:0]           awsize,
    input  logic [1:0]           awburst,
    input  logic [ID-1:0]        awid,
    input  logic                 awlock,
    input  logic [3:0]           awcache,
    input  logic [2:0]           awprot,
    input  logic [3:0]           awqos,
    // read address
    input  logic                 arvalid,
    output logic                 arready,
    input  logic [ADDR-1:0]      araddr,
    input  logic [LENBITS-1:0]   arlen,
    input  logic [2:0]           arsize,
    input  logic [1:0]           arburst,
    input  logic [ID-1:0]        arid,
    input  logic                 arlock,
    input  logic [3:0]           arcache,
    input  logic [2:0]           arprot,
    input  logic [3:0]           arqos,
    // write data
    input  logic                 wvalid,
    output logic                 wready,
    input  logic [DATA-1:0]      wdata,
    input  logic [DATA/8-1:0]    wstrb,
    input  logic                 wlast,
    input  logic [ID-1:0]        wid,
    // write response
    output logic                 bvalid,
    input  logic                 bready,
    output logic [1:0]           bresp,
    output logic [ID-1:0]        bid,
    // read data
    output logic                 rvalid,
    input  logic                 rready,
    output logic [DATA-1:0]      rdata,
    output logic [1:0]           rresp,
    output logic                 rlast,
    output logic [ID-1:0]        rid,
    // register bus
    output logic                 outreq,
    output logic                 outwr,
    output logic [ADDR-1:0]      outaddr,
    output logic [DATA-1:0]      outwdata,
    output logic [DATA/8-1:0]    outwstrb,
    input  logic [DATA-1:0]      outrdata,
    input  logic                 outack,
    input  logic                 outerr
);

    localparam int unsigned STRB   = DATA / 8;
    localparam bit          TMO_EN = (TIMEOUT != 0);

    state_e               state_q, state_d;
    logic                 rr_rd_q, rr_rd_d;
    logic [LENBITS-1:0]   cnt_q, cnt_d;
    logic [LENBITS-1:0]   len_q, len_d;
    logic [2:0]           size_q, size_d;
    burst_e               burst_q, burst_d;
    logic [ID-1:0]        id_q, id_d;
    logic [ADDR-1:0]      addr_q, addr_d;
    logic [DATA-1:0]      wdata_q, wdata_d;
    logic [STRB-1:0]      wstrb_q, wstrb_d;
    logic [DATA-1:0]      rdata_q, rdata_d;
    resp_e                rresp_q, rresp_d;
    resp_e                bresp_q, bresp_d;
    logic [TIMEBITS-1:0]  tmo_q, tmo_d;
    logic                 outreq_q, outreq_d;
    logic                 outwr_q, outwr_d;
    logic                 awready_q, awready_d;
    logic                 arready_q, arready_d;
    logic                 wready_q, wready_d;
    logic                 bvalid_q, bvalid_d;
    logic                 rvalid_q, rvalid_d;
    logic                 rlast_q, rlast_d;

    logic [ADDR-1:0]      next_addr_c;
    logic                 beat_ack_c;
    logic                 beat_tmo_c;
    logic                 beat_done_c;
    resp_e                beat_resp_c;
    logic                 take_aw_c;
    logic                 take_ar_c;

    axi_addr_gen #(
        .ADDR    (ADDR),
        .LENBITS (LENBITS)
    ) u_addr_gen (
        .addr        (addr_q),
        .size        (size_q),
        .len         (len_q),
        .burst       (burst_q),
        .next_addr_c (next_addr_c)
    );

    // A beat ends on an acknowledge or when the timer is about to expire; outack is ignored while idle.
    assign beat_ack_c  = outreq_q && outack;
    assign beat_tmo_c  = TMO_EN && outreq_q && !outack && (tmo_q == TIMEBITS'(1));
    assign beat_done_c = beat_ack_c || beat_tmo_c;
    assign beat_resp_c = beat_tmo_c ? RESP_DECERR : (outerr ? RESP_SLVERR : RESP_OKAY);

    // Round robin: the channel not served last wins a simultaneous request.
    assign take_aw_c = awvalid && (!arvalid || rr_rd_q);
    assign take_ar_c = arvalid && !take_aw_c;

    always_comb begin
        state_d = state_q;
        rr_rd_d = rr_rd_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        size_d  = size_q;
        burst_d = burst_q;
        id_d    = id_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        bresp_d = bresp_q;

        case (state_q)
            ST_IDLE: begin
                if (take_aw_c) begin
                    addr_d  = awaddr;
                    len_d   = awlen;
                    cnt_d   = awlen;
                    size_d  = awsize;
                    burst_d = burst_e'(awburst);
                    id_d    = awid;
                    bresp_d = (burst_e'(awburst) == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
                    rr_rd_d = 1'b0;
                    state_d = ST_WRDATA;
                end else if (take_ar_c) begin
                    addr_d  = araddr;
                    len_d   = arlen;
                    cnt_d   = arlen;
                    size_d  = arsize;
                    burst_d = burst_e'(arburst);
                    id_d    = arid;
                    rr_rd_d = 1'b1;
                    if (burst_e'(arburst) == BURST_RSVD) begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                        state_d = ST_RDRESP;
                    end else begin
                        state_d = ST_RDREQ;
                    end
                end
            end
            ST_RDREQ: begin
                if (beat_done_c) begin
                    rdata_d = beat_ack_c ? outrdata : '0;
                    rresp_d = beat_resp_c;
                    state_d = ST_RDRESP;
                end
            end
            ST_RDRESP: begin
                if (rready) begin
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d   = cnt_q - LENBITS'(1);
                        addr_d  = next_addr_c;
                        state_d = (burst_q == BURST_RSVD) ? ST_RDRESP : ST_RDREQ;
                    end
                end
            end
            ST_WRDATA: begin
                if (wvalid) begin
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                    // Empty strobes and reserved bursts consume the beat without touching the bus.
                    if ((wstrb == '0) || (burst_q == BURST_RSVD)) begin
                        if (cnt_q == '0) begin
                            state_d = ST_WRRESP;
                        end else begin
                            cnt_d  = cnt_q - LENBITS'(1);
                            addr_d = next_addr_c;
                        end
                    end else begin
                        state_d = ST_WRREQ;
                    end
                end
            end
            ST_WRREQ: begin
                if (beat_done_c) begin
                    bresp_d = resp_worst(bresp_q, beat_resp_c);
                    if (cnt_q == '0) begin
                        state_d = ST_WRRESP;
                    end else begin
                        cnt_d   = cnt_q - LENBITS'(1);
                        addr_d  = next_addr_c;
                        state_d = ST_WRDATA;
                    end
                end
            end
            ST_WRRESP: begin
                if (bready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        awready_d = (state_d == ST_IDLE);
        arready_d = (state_d == ST_IDLE);
        wready_d  = (state_d == ST_WRDATA);
        bvalid_d  = (state_d == ST_WRRESP);
        rvalid_d  = (state_d == ST_RDRESP);
        rlast_d   = (state_d == ST_RDRESP) && (cnt_d == '0);
        outreq_d  = (state_d == ST_RDREQ) || (state_d == ST_WRREQ);
        outwr_d   = (state_d == ST_WRREQ);

        // Timer reloads on every new request and counts down while it is outstanding.
        tmo_d = tmo_q;
        if (outreq_d && !outreq_q) begin
            tmo_d = TIMEBITS'(TIMEOUT);
        end else if (outreq_q && (tmo_q != '0)) begin
            tmo_d = tmo_q - TIMEBITS'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            rr_rd_q   <= 1'b1;
            cnt_q     <= '0;
            len_q     <= '0;
            size_q    <= '0;
            burst_q   <= BURST_FIXED;
            id_q      <= '0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            bresp_q   <= RESP_OKAY;
            tmo_q     <= '0;
            outreq_q  <= 1'b0;
            outwr_q   <= 1'b0;
            awready_q <= 1'b1;
            arready_q <= 1'b1;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_rd_q   <= rr_rd_d;
            cnt_q     <= cnt_d;
            len_q     <= len_d;
            size_q    <= size_d;
            burst_q   <= burst_d;
            id_q      <= id_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            bresp_q   <= bresp_d;
            tmo_q     <= tmo_d;
            outreq_q  <= outreq_d;
            outwr_q   <= outwr_d;
            awready_q <= awready_d;
            arready_q <= arready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
            rvalid_q  <= rvalid_d;
            rlast_q   <= rlast_d;
        end
    end

    assign awready  = awready_q;
    assign arready  = arready_q;
    assign wready   = wready_q;
    assign bvalid   = bvalid_q;
    assign bresp    = bresp_q;
    assign bid      = id_q;
    assign rvalid   = rvalid_q;
    assign rdata    = rdata_q;
    assign rresp    = rresp_q;
    assign rlast    = rlast_q;
    assign rid      = id_q;
    assign outreq   = outreq_q;
    assign outwr    = outwr_q;
    assign outaddr  = addr_q;
    assign outwdata = wdata_q;
    assign outwstrb = wstrb_q;

    // Sideband fields are accepted but carry no meaning for this bridge.
    logic unused_ok;
    assign unused_ok = ^{awlock, awcache, awprot, awqos,
                         arlock, arcache, arprot, arqos, wlast, wid};

endmodule

// File: tb/tb_axi_slave_bridge.sv
// Directed self-checking bench for axi_slave_bridge with a hand-driven register bus.
module tb_axi_slave_bridge;
    import axi_pkg::*;

    localparam int unsigned ADDR     = 32;
    localparam int unsigned DATA     = 32;
    localparam int unsigned ID       = 12;
    localparam int unsigned LENBITS  = 4;
    localparam int unsigned TIMEBITS = 20;
    localparam int unsigned TIMEOUT  = 16;

    logic               clk = 1'b0;
    logic               resetn;
    logic               awvalid, awready;
    logic [ADDR-1:0]    awaddr;
    logic [LENBITS-1:0] awlen;
    logic [2:0]         awsize;
    logic [1:0]         awburst;
    logic [ID-1:0]      awid;
    logic               arvalid, arready;
    logic [ADDR-1:0]    araddr;
    logic [LENBITS-1:0] arlen;
    logic [2:0]         arsize;
    logic [1:0]         arburst;
    logic [ID-1:0]      arid;
    logic               wvalid, wready;
    logic [DATA-1:0]    wdata;
    logic [DATA/8-1:0]  wstrb;
    logic               wlast;
    logic               bvalid, bready;
    logic [1:0]         bresp;
    logic [ID-1:0]      bid;
    logic               rvalid, rready;
    logic [DATA-1:0]    rdata;
    logic [1:0]         rresp;
    logic               rlast;
    logic [ID-1:0]      rid;
    logic               outreq, outwr;
    logic [ADDR-1:0]    outaddr;
    logic [DATA-1:0]    outwdata;
    logic [DATA/8-1:0]  outwstrb;
    logic [DATA-1:0]    outrdata;
    logic               outack, outerr;

    int n_asserts = 0;
    int n_fails   = 0;

    axi_slave_bridge #(
        .ADDR(ADDR), .DATA(DATA), .ID(ID), .LENBITS(LENBITS),
        .TIMEBITS(TIMEBITS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .resetn(resetn),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
        .awsize(awsize), .awburst(awburst), .awid(awid), .awlock(1'b0),
        .awcache(4'h0), .awprot(3'h0), .awqos(4'h0),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .arsize(arsize), .arburst(arburst), .arid(arid), .arlock(1'b0),
        .arcache(4'h0), .arprot(3'h0), .arqos(4'h0),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .wlast(wlast), .wid(12'h0),
        .bvalid(bvalid), .bready(bready), .bresp(bresp), .bid(bid),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .rlast(rlast), .rid(rid),
        .outreq(outreq), .outwr(outwr), .outaddr(outaddr), .outwdata(outwdata),
        .outwstrb(outwstrb), .outrdata(outrdata), .outack(outack), .outerr(outerr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_outreq(input string tag);
        int n = 0;
        while (outreq !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(outreq), 64'(1));
    endtask

    task automatic wait_rvalid(input string tag);
        int n = 0;
        while (rvalid !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(rvalid), 64'(1));
    endtask

    task automatic start_rd(input logic [31:0] a, input logic [3:0] len,
                            input logic [1:0] burst, input logic [11:0] id);
        araddr = a; arlen = len; arsize = 3'd2; arburst = burst; arid = id;
        arvalid = 1'b1;
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic start_wr(input logic [31:0] a, input logic [3:0] len,
                            input logic [1:0] burst, input logic [11:0] id);
        awaddr = a; awlen = len; awsize = 3'd2; awburst = burst; awid = id;
        awvalid = 1'b1;
        @(negedge clk);
        awvalid = 1'b0;
    endtask

    task automatic rd_beat(input string tag, input logic [31:0] exp_addr, input logic [31:0] data,
                           input logic exp_last, input logic [11:0] exp_id);
        wait_outreq({tag, "_req"});
        chk({tag, "_addr"}, 64'(outaddr), 64'(exp_addr));
        chk({tag, "_outwr"}, 64'(outwr), 64'(0));
        outack = 1'b1; outerr = 1'b0; outrdata = data;
        @(negedge clk);
        outack = 1'b0; outrdata = '0;
        wait_rvalid({tag, "_rvalid"});
        chk({tag, "_rdata"}, 64'(rdata), 64'(data));
        chk({tag, "_rresp"}, 64'(rresp), 64'(RESP_OKAY));
        chk({tag, "_rlast"}, 64'(rlast), 64'(exp_last));
        chk({tag, "_rid"}, 64'(rid), 64'(exp_id));
        chk({tag, "_reqdrop"}, 64'(outreq), 64'(0));
        rready = 1'b1;
        @(negedge clk);
        rready = 1'b0;
    endtask

    // mode 0: ack OKAY, 1: ack with outerr, 2: never acked (timeout) then a late ack
    task automatic wr_beat(input string tag, input logic [31:0] exp_addr, input logic [31:0] data,
                           input logic [3:0] strb, input int mode);
        int n = 0;
        while (wready !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_wready"}, 64'(wready), 64'(1));
        wvalid = 1'b1; wdata = data; wstrb = strb; wlast = 1'b0;
        @(negedge clk);
        wvalid = 1'b0;
        if (strb == 4'h0) begin
            chk({tag, "_noreq"}, 64'(outreq), 64'(0));
            return;
        end
        wait_outreq({tag, "_req"});
        chk({tag, "_addr"}, 64'(outaddr), 64'(exp_addr));
        chk({tag, "_outwr"}, 64'(outwr), 64'(1));
        chk({tag, "_wdata"}, 64'(outwdata), 64'(data));
        chk({tag, "_wstrb"}, 64'(outwstrb), 64'(strb));
        if (mode == 2) begin
            n = 0;
            while (outreq === 1'b1 && n < 64) begin
                @(negedge clk);
                n++;
            end
            chk({tag, "_tmo_cycles"}, 64'(n), 64'(TIMEOUT));
            outack = 1'b1;
            @(negedge clk);
            outack = 1'b0;
            chk({tag, "_late_ack_req"}, 64'(outreq), 64'(0));
            chk({tag, "_late_ack_wready"}, 64'(wready), 64'(1));
        end else begin
            outack = 1'b1; outerr = (mode == 1);
            @(negedge clk);
            outack = 1'b0; outerr = 1'b0;
            chk({tag, "_reqdrop"}, 64'(outreq), 64'(0));
        end
    endtask

    task automatic finish_wr(input string tag, input logic [1:0] exp_resp, input logic [11:0] exp_id);
        int n = 0;
        while (bvalid !== 1'b1 && n < 64) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_bvalid"}, 64'(bvalid), 64'(1));
        chk({tag, "_bresp"}, 64'(bresp), 64'(exp_resp));
        chk({tag, "_bid"}, 64'(bid), 64'(exp_id));
        chk({tag, "_wready_off"}, 64'(wready), 64'(0));
        bready = 1'b1;
        @(negedge clk);
        bready = 1'b0;
        chk({tag, "_bvalid_off"}, 64'(bvalid), 64'(0));
        chk({tag, "_awready_idle"}, 64'(awready), 64'(1));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0;
        awvalid = 0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awid = '0;
        arvalid = 0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arid = '0;
        wvalid = 0; wdata = '0; wstrb = '0; wlast = 0;
        bready = 0; rready = 0;
        outrdata = '0; outack = 0; outerr = 0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_awready", 64'(awready), 64'(1));
        chk("rst_arready", 64'(arready), 64'(1));
        chk("rst_wready", 64'(wready), 64'(0));
        chk("rst_bvalid", 64'(bvalid), 64'(0));
        chk("rst_rvalid", 64'(rvalid), 64'(0));
        chk("rst_rlast", 64'(rlast), 64'(0));
        chk("rst_outreq", 64'(outreq), 64'(0));
        chk("rst_outwr", 64'(outwr), 64'(0));
        chk("rst_bresp", 64'(bresp), 64'(RESP_OKAY));
        chk("rst_rresp", 64'(rresp), 64'(RESP_OKAY));

        // INCR read, 4 beats
        start_rd(32'h100, 4'd3, BURST_INCR, 12'h5A5);
        rd_beat("incr_rd0", 32'h100, 32'hCAFE_0000, 1'b0, 12'h5A5);
        rd_beat("incr_rd1", 32'h104, 32'hCAFE_0001, 1'b0, 12'h5A5);
        rd_beat("incr_rd2", 32'h108, 32'hCAFE_0002, 1'b0, 12'h5A5);
        rd_beat("incr_rd3", 32'h10C, 32'hCAFE_0003, 1'b1, 12'h5A5);
        chk("incr_rd_done", 64'(rvalid), 64'(0));

        // Simultaneous AW/AR twice: last served was a read, so AW wins, then AR
        awaddr = 32'h400; awlen = 4'd0; awsize = 3'd2; awburst = BURST_INCR; awid = 12'h011;
        araddr = 32'h500; arlen = 4'd0; arsize = 3'd2; arburst = BURST_INCR; arid = 12'h022;
        awvalid = 1'b1; arvalid = 1'b1;
        @(negedge clk);
        chk("arb1_wready", 64'(wready), 64'(1));
        chk("arb1_arready", 64'(arready), 64'(0));
        awaddr = 32'h600; awid = 12'h033;
        wr_beat("arb1_wr", 32'h400, 32'h1111_2222, 4'hF, 0);
        finish_wr("arb1", RESP_OKAY, 12'h011);
        @(negedge clk);
        arvalid = 1'b0;
        chk("arb2_wready", 64'(wready), 64'(0));
        rd_beat("arb2_rd", 32'h500, 32'h3333_4444, 1'b1, 12'h022);
        chk("arb2_done", 64'(rvalid), 64'(0));
        @(negedge clk);
        awvalid = 1'b0;
        wr_beat("arb3_wr", 32'h600, 32'h5555_6666, 4'hF, 0);
        finish_wr("arb3", RESP_OKAY, 12'h033);

        // WRAP write 0x38, 4 beats of 4 bytes
        start_wr(32'h38, 4'd3, BURST_WRAP, 12'h123);
        wr_beat("wrap0", 32'h38, 32'hA000_0000, 4'hF, 0);
        wr_beat("wrap1", 32'h3C, 32'hA000_0001, 4'hF, 0);
        wr_beat("wrap2", 32'h30, 32'hA000_0002, 4'h3, 0);
        wr_beat("wrap3", 32'h34, 32'hA000_0003, 4'hF, 0);
        finish_wr("wrap", RESP_OKAY, 12'h123);

        // Error merge: OKAY, SLVERR, timeout, OKAY -> DECERR
        start_wr(32'h200, 4'd3, BURST_INCR, 12'h044);
        wr_beat("err0", 32'h200, 32'hB000_0000, 4'hF, 0);
        wr_beat("err1", 32'h204, 32'hB000_0001, 4'hF, 1);
        wr_beat("err2", 32'h208, 32'hB000_0002, 4'hF, 2);
        wr_beat("err3", 32'h20C, 32'hB000_0003, 4'hF, 0);
        finish_wr("err", RESP_DECERR, 12'h044);

        // Zero-strobe beat skips the bus but still counts
        start_wr(32'h300, 4'd2, BURST_INCR, 12'h055);
        wr_beat("zs0", 32'h300, 32'hC000_0000, 4'hF, 0);
        wr_beat("zs1", 32'h304, 32'hC000_0001, 4'h0, 0);
        wr_beat("zs2", 32'h308, 32'hC000_0002, 4'hF, 0);
        finish_wr("zs", RESP_OKAY, 12'h055);

        // Reserved read burst: two SLVERR beats, no bus access
        start_rd(32'h900, 4'd1, BURST_RSVD, 12'h066);
        chk("rsvd_b0_outreq", 64'(outreq), 64'(0));
        chk("rsvd_b0_rvalid", 64'(rvalid), 64'(1));
        chk("rsvd_b0_rresp", 64'(rresp), 64'(RESP_SLVERR));
        chk("rsvd_b0_rlast", 64'(rlast), 64'(0));
        chk("rsvd_b0_rid", 64'(rid), 64'(12'h066));
        rready = 1'b1;
        @(negedge clk);
        chk("rsvd_b1_outreq", 64'(outreq), 64'(0));
        chk("rsvd_b1_rvalid", 64'(rvalid), 64'(1));
        chk("rsvd_b1_rresp", 64'(rresp), 64'(RESP_SLVERR));
        chk("rsvd_b1_rlast", 64'(rlast), 64'(1));
        @(negedge clk);
        rready = 1'b0;
        chk("rsvd_done", 64'(rvalid), 64'(0));

        // Reset while a read response is pending
        start_rd(32'h700, 4'd1, BURST_INCR, 12'h0AB);
        wait_outreq("rst_mid_req");
        outack = 1'b1; outrdata = 32'hDEAD_BEEF;
        @(negedge clk);
        outack = 1'b0;
        chk("rst_mid_rvalid_pre", 64'(rvalid), 64'(1));
        #2 resetn = 1'b0;
        #1;
        chk("rst_mid_rvalid", 64'(rvalid), 64'(0));
        chk("rst_mid_outreq", 64'(outreq), 64'(0));
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_post_awready", 64'(awready), 64'(1));
        chk("rst_post_arready", 64'(arready), 64'(1));
        chk("rst_post_rvalid", 64'(rvalid), 64'(0));
        chk("rst_post_bvalid", 64'(bvalid), 64'(0));
        start_rd(32'h800, 4'd0, BURST_INCR, 12'h0CD);
        rd_beat("rst_post_rd", 32'h800, 32'h1234_5678, 1'b1, 12'h0CD);
        chk("rst_post_done", 64'(rvalid), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule

// File: doc/axi_slave_bridge.md
# axi_slave_bridge

Parametrised AXI3/AXI4 slave that converts AXI bursts into single-beat requests on the team's simple request/acknowledge register bus (`outreq`/`outack`). Sits between the PS interconnect and local register/memory blocks. It generalises the earlier bridge with:

- configurable burst-length width;
- full FIXED/INCR/WRAP address generation;
- fair read/write arbitration;
- worst-case write-response merging;
- a parameterisable per-beat timeout.

## Interface
- ADDR, 32, address width
- DATA, 32, data width (power of two, 8..1024)
- ID, 12, AXI ID width
- LENBITS, 4, AxLEN width (4 = AXI3, 8 = AXI4)
- TIMEBITS, 20, timeout counter width
- TIMEOUT, 2**TIMEBITS-1, cycles per bus beat before DECERR; 0 disables
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- awvalid/awready, arvalid/arready  in/out  1  address handshakes
- awaddr, araddr  in  ADDR  start address
- awlen, arlen  in  LENBITS  beats-1
- awsize, arsize  in  3  log2 bytes/beat (≤ log2(DATA/8))
- awburst, arburst  in  2  0 FIXED, 1 INCR, 2 WRAP, 3 reserved
- awid, arid  in  ID  transaction ID
- awlock/arlock, awcache/arcache, awprot/arprot, awqos/arqos  in  —  accepted, ignored
- wvalid/wready  in/out  1  write data handshake
- wdata, wstrb, wlast, wid  in  DATA, DATA/8, 1, ID  write beat
- bvalid/bready, bresp, bid  out/in, out, out  1, 2, ID  write response
- rvalid/rready, rdata, rresp, rlast, rid  out/in, out, out, out, out  1, DATA, 2, 1, ID  read beat
- outreq  out  1  bus request, held until outack or timeout
- outwr  out  1  1 = write beat
- outaddr  out  ADDR  beat address
- outwdata, outwstrb  out  DATA, DATA/8  write data and strobes
- outrdata  in  DATA  read data, sampled on outack
- outack, outerr  in  1  beat done; outerr valid with outack

## Operation
- States: IDLE, RDREQ, RDRESP, WRDATA, WRREQ, WRRESP.
- IDLE:
  - awready = arready = 1.
  - Exactly one channel is accepted per cycle.
  - If both are valid, the one not served last wins (1-bit round-robin flag; reset favours write). The loser stays pending and is not latched.
- Reserved burst (3):
  - Read: returns len+1 beats with SLVERR and no bus access.
  - Write: consumes all beats, then bresp = SLVERR.
- Address generation per beat (sub-module), where size_bytes = 1<<size:
  - FIXED: address unchanged.
  - INCR: addr + size_bytes.
  - WRAP: container = (len+1)*size_bytes, boundary = addr & ~(container-1); next = boundary | ((addr + size_bytes) & (container-1)).
  - WRAP requires len+1 ∈ {2,4,8,16}; otherwise it is treated as INCR.
  - Address arithmetic wraps modulo 2^ADDR.
- Read path:
  - RDREQ: assert outreq; on outack or timeout, latch rdata/err and go to RDRESP.
  - RDRESP: rvalid = 1. rresp = DECERR on timeout, else SLVERR on outerr, else OKAY. rlast when the beat counter is 0.
  - On rready: last beat → IDLE; otherwise advance the address and go to RDREQ.
- Write path:
  - WRDATA: wready = 1. On wvalid, latch the beat.
  - wstrb == 0: no bus access; the counter still advances.
  - Otherwise go to WRREQ; it completes on outack or timeout.
  - The burst ends on beat count, not on wlast; a wlast mismatch is ignored.
- bresp is the worst error over the burst (DECERR > SLVERR > OKAY), cleared on AW accept.
- WRRESP: bvalid = 1; on bready → IDLE.
- bid and rid come from the latched awid/arid. wid is ignored (no interleaving).

## Timing
- Reset: state IDLE, rr flag = write. awready = arready = 1 in IDLE. wready, bvalid, rvalid, rlast, outreq, outwr = 0. bresp, rresp = OKAY.
- Reset mid-burst aborts immediately; no responses are issued.
- Read latency: AR accepted at cycle 0, outreq at 1, outack at k, rvalid at k+1.
  - With rready held high, next outreq at k+2.
- Write latency: AW accepted at 0, wready at 1, W accepted at w, outreq at w+1, outack at k, wready again at k+1.
  - After the last beat, bvalid at k+1.
- outreq drops in the cycle after outack. outack is ignored while outreq = 0.
- Timeout counter:
  - Loads TIMEOUT on each outreq rising edge and decrements while outreq = 1.
  - Reaching 0 ends the beat with DECERR. A late outack is then ignored.
- outaddr, outwr, outwdata and outwstrb are stable while outreq = 1.

## Structure
- Package axi_pkg: resp codes (OKAY, EXOKAY, SLVERR, DECERR), burst codes (FIXED, INCR, WRAP), state encoding.
- Sub-module axi_addr_gen: combinational next-address from addr, size, len, burst.

## Test plan
- INCR read, araddr 0x100, arlen 3, size 2, immediate outack → outaddr 0x100, 0x104, 0x108, 0x10C; 4 beats OKAY; rlast only on beat 4; rid = arid.
- WRAP write, awaddr 0x38, awlen 3, size 2 → outaddr 0x38, 0x3C, 0x30, 0x34; bresp OKAY.
- AW and AR valid in the same cycle, twice in a row → first AW, then AR; the losing channel's payload is unchanged at acceptance.
- 4-beat write: beat 2 outerr = 1, beat 3 never acked with TIMEOUT = 16 → beat 3 ends after 16 cycles; bresp = DECERR.
- Write beat with wstrb = 0 → no outreq for it; beat count still advances; the burst ends after len+1 beats.
- resetn low during RDRESP → rvalid = 0 immediately; after release: IDLE with awready = arready = 1; a new read completes normally.
